keynsham_wait_ram: RTL and testbench
====================================

KEYNSHAM_WAIT_RAM -- requirements
Module: keynsham_wait_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12: word-address width; DEPTH = 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter D_LATENCY, default 1: data-port cycles from request acceptance to d_ack; legal range 1..8.
REQ-003 SHALL have parameter PROT_WORDS, default 0: number of write-protected low words. Used only with REQ-030.
REQ-004 SHALL have one clock and reset: asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_addr, input, 32 bits: instruction byte address; bits [ADDR_BITS+1:2] used.
REQ-008 SHALL have port i_access, input, 1 bit: instruction fetch request.
REQ-009 SHALL have port i_data, output, 32 bits: fetched instruction word.
REQ-010 SHALL have port i_ack, output, 1 bit: i_data valid this cycle.
REQ-011 SHALL have port d_access, input, 1 bit: data bus cycle active.
REQ-012 SHALL have port d_cs, input, 1 bit: RAM selected by the external decoder.
REQ-013 SHALL have port d_addr, input, 32 bits: data byte address; bits [ADDR_BITS+1:2] used.
REQ-014 SHALL have port d_bytesel, input, 4 bits: byte enables; bit n covers d_wr_val[8n+7:8n].
REQ-015 SHALL have port d_wr_val, input, 32 bits: write data.
REQ-016 SHALL have port d_wr_en, input, 1 bit: 1 = write, 0 = read.
REQ-017 SHALL have port d_data, output, 32 bits: read data.
REQ-018 SHALL have port d_ack, output, 1 bit: one-cycle completion pulse.
REQ-019 SHALL have port d_error, output, 1 bit: pulses with d_ack on a rejected write.

Function
REQ-020 SHALL ignore address bits above ADDR_BITS+1; addresses wrap modulo DEPTH words.
- I-port: fully pipelined; i_access sampled at edge N gives i_ack=1 and i_data=mem[i_addr] at cycle N+1.
- Back-to-back fetches every cycle SHALL be supported; i_data SHALL hold its value when i_ack=0.
REQ-021 SHALL use a two-state data FSM, IDLE/BUSY, with a latency counter.
- In IDLE, d_access&&d_cs at an edge accepts the request and latches address, bytesel, write data and direction.
- D_LATENCY=1: d_ack=1 in the next cycle and the FSM stays IDLE, so a new request can be accepted in that ack cycle.
- D_LATENCY>1: FSM goes to BUSY and counts down. d_ack=1 for exactly one cycle, D_LATENCY cycles after acceptance; FSM returns to IDLE on the ack edge.
REQ-022 SHALL ignore requests arriving while BUSY; no queueing. The requester holds d_access until d_ack.
REQ-023 SHALL commit a write at the acceptance edge, updating only the bytes with d_bytesel set.
- d_bytesel=0 SHALL still be acked, with memory unchanged.
REQ-024 SHALL return on a read, in the d_ack cycle, the memory contents at the acceptance edge.
- d_data SHALL hold until the next read ack.
- d_data SHALL be unchanged by write acks.
REQ-025 SHALL apply read-before-write when an I-port fetch and a D-port write hit the same word at the same edge: i_data returns the old word.
REQ-026 SHALL never acknowledge a request that was not accepted. d_ack and i_ack SHALL never exceed one pulse per accepted request.

Reset
REQ-027 SHALL force, while rst=1: i_ack=0, d_ack=0, d_error=0, i_data=0, d_data=0, FSM=IDLE, counter=0.
REQ-028 SHALL drop an in-flight transaction on reset mid-operation: no ack after reset releases. A write already committed SHALL remain.
REQ-029 SHALL not initialise or clear memory contents on reset.

Configuration
REQ-030 SHALL compile in write protection when KEYNSHAM_RAM_WRPROT_EN is defined.
- A write with word index < PROT_WORDS SHALL not modify memory.
- It SHALL still be acked normally, with d_error=1 in the d_ack cycle.
- Without the macro: PROT_WORDS is ignored, all writes commit, and d_error is tied to 0.

Verification
REQ-031 SHALL cover, with D_LATENCY=1: write 0xDEADBEEF to 0x10 with bytesel 4'b1111, then read 0x10. Required: d_ack pulses 1 cycle after each acceptance, d_data=0xDEADBEEF.
REQ-032 SHALL cover, with D_LATENCY=3: read held with d_access=1. Required: d_ack exactly 3 cycles after acceptance, one cycle wide; no second ack while d_access is still high during BUSY.
REQ-033 SHALL cover a byte-lane write: 0x11223344 to word 0x20 pre-filled with 0xAAAAAAAA, bytesel 4'b0101. Required readback 0xAA22AA44.
REQ-034 SHALL cover, with ADDR_BITS=4: write to byte address 0x40. Required: the write aliases to word 0, and a fetch from i_addr=0x0 returns the value with i_ack one cycle after.
REQ-035 SHALL cover an I-fetch and D-write to the same word at the same edge. Required: i_data equals the old value; a fetch at the next cycle returns the new value.
REQ-036 SHALL cover, with the macro defined and PROT_WORDS=4: write to 0x08. Required: d_ack=1 and d_error=1, memory unchanged. Also: rst asserted mid-BUSY gives no d_ack after release.

Source files
------------

// File: rtl/keynsham_wait_ram_if.sv
// Instruction-fetch and data-bus signal bundle for keynsham_wait_ram.
// master drives requests; slave is the RAM.
interface keynsham_wait_ram_if;
  logic [31:0] i_addr;
  logic        i_access;
  logic [31:0] i_data;
  logic        i_ack;
  logic        d_access;
  logic        d_cs;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en;
  logic [31:0] d_data;
  logic        d_ack;
  logic        d_error;

  modport master (
    output i_addr, i_access, d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en,
    input  i_data, i_ack, d_data, d_ack, d_error
  );

  modport slave (
    input  i_addr, i_access, d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en,
    output i_data, i_ack, d_data, d_ack, d_error
  );
endinterface

// File: rtl/keynsham_wait_ram.sv
// Dual-port word RAM: pipelined instruction fetch port plus a wait-stated data port.
// Optional write protection of the low PROT_WORDS words via KEYNSHAM_RAM_WRPROT_EN.
module keynsham_wait_ram #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned D_LATENCY  = 1,
  parameter int unsigned PROT_WORDS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  keynsham_wait_ram_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]          r_mem [DEPTH];

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_d_ack, w_ack_nxt;
  logic                 r_d_err, w_err_nxt;
  logic [31:0]          r_d_data;
  logic [31:0]          r_rd_buf;
  logic                 r_wr;
  logic                 r_err;
  logic                 r_i_ack;
  logic [31:0]          r_i_data;

  logic [ADDR_BITS-1:0] w_i_idx, w_d_idx;
  logic [31:0]          w_d_rdata;
  logic                 w_accept;
  logic                 w_prot_hit;
  logic                 w_wr_block;
  logic                 w_commit;
  logic                 w_rd_ld;
  logic [31:0]          w_rd_src;
  logic                 w_unused_addr;

  assign w_i_idx       = bus.i_addr[ADDR_BITS+1:2];
  assign w_d_idx       = bus.d_addr[ADDR_BITS+1:2];
  assign w_d_rdata     = r_mem[w_d_idx];
  assign w_unused_addr = ^{bus.i_addr, bus.d_addr};

`ifdef KEYNSHAM_RAM_WRPROT_EN
  assign w_prot_hit = (32'(w_d_idx) < 32'(PROT_WORDS));
`else
  logic w_unused_prot;
  assign w_prot_hit    = 1'b0;
  assign w_unused_prot = (PROT_WORDS != 0);
`endif

  assign w_accept   = (r_state == IDLE) && bus.d_access && bus.d_cs && !rst;
  assign w_wr_block = w_prot_hit && bus.d_wr_en;
  assign w_commit   = w_accept && bus.d_wr_en && !w_prot_hit;

  // Writes land at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.d_bytesel[b]) r_mem[w_d_idx][8*b +: 8] <= bus.d_wr_val[8*b +: 8];
      end
    end
  end

  // Instruction port: one-cycle pipelined read, data held between acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_ack  <= 1'b0;
      r_i_data <= '0;
    end else begin
      r_i_ack <= bus.i_access;
      if (bus.i_access) r_i_data <= r_mem[w_i_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latency 1 acks straight from IDLE; longer latencies count down in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_ld     = 1'b0;
    w_rd_src    = r_rd_buf;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (D_LATENCY == 1) begin
            w_ack_nxt = 1'b1;
            w_err_nxt = w_wr_block;
            w_rd_ld   = !bus.d_wr_en;
            w_rd_src  = w_d_rdata;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_W'(D_LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = r_err;
          w_rd_ld     = !r_wr;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data is snapshotted at acceptance so later writes cannot leak into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      r_d_data <= '0;
      r_rd_buf <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_d_ack <= w_ack_nxt;
      r_d_err <= w_err_nxt;
      if (w_rd_ld) r_d_data <= w_rd_src;
      if (w_accept) begin
        r_rd_buf <= w_d_rdata;
        r_wr     <= bus.d_wr_en;
        r_err    <= w_wr_block;
      end
    end
  end

  assign bus.i_ack   = r_i_ack;
  assign bus.i_data  = r_i_data;
  assign bus.d_ack   = r_d_ack;
  assign bus.d_error = r_d_err;
  assign bus.d_data  = r_d_data;

endmodule

// File: tb/tb_keynsham_wait_ram.sv
// Scoreboard bench: instance A (12-bit, latency 1, 4 protected words), instance B (4-bit, latency 3).
module tb_keynsham_wait_ram;

  typedef struct {
    int          inst;
    logic [31:0] data;
    bit          chk;
    bit          rd;
    bit          err;
    int          due;
  } exp_t;

`ifdef KEYNSHAM_RAM_WRPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qd[$];
  exp_t qi[$];
  logic [31:0] hold_i [2];
  logic [31:0] hold_d [2];

  keynsham_wait_ram_if ba ();
  keynsham_wait_ram_if bb ();

  keynsham_wait_ram #(.ADDR_BITS(12), .D_LATENCY(1), .PROT_WORDS(4)) u_a (
    .clk(clk), .rst(rst_a), .bus(ba)
  );
  keynsham_wait_ram #(.ADDR_BITS(4), .D_LATENCY(3), .PROT_WORDS(0)) u_b (
    .clk(clk), .rst(rst_b), .bus(bb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic monitor_step(input int k, input logic rst, input logic iack, input logic [31:0] idata,
                              input logic dack, input logic [31:0] ddata, input logic derr);
    exp_t  e;
    string t;
    t = (k == 0) ? "A" : "B";
    if (rst) begin
      hold_i[k] = '0;
      hold_d[k] = '0;
      return;
    end
    if (iack) begin
      if (qi.size() == 0 || qi[0].inst != k) flag({t, " unexpected i_ack"});
      else begin
        e = qi.pop_front();
        chk({t, " i_data"}, idata, e.data);
        chk({t, " i_ack cycle"}, 32'(cyc), 32'(e.due));
        hold_i[k] = e.data;
      end
    end else begin
      chk({t, " i_data hold"}, idata, hold_i[k]);
    end
    if (dack) begin
      if (qd.size() == 0 || qd[0].inst != k) flag({t, " unexpected d_ack"});
      else begin
        e = qd.pop_front();
        chk({t, " d_error"}, 32'(derr), 32'(e.err));
        chk({t, " d_ack cycle"}, 32'(cyc), 32'(e.due));
        if (e.rd && e.chk) begin
          chk({t, " d_data read"}, ddata, e.data);
          hold_d[k] = e.data;
        end else if (e.rd) begin
          hold_d[k] = ddata;
        end else begin
          chk({t, " d_data after write"}, ddata, hold_d[k]);
        end
      end
    end else begin
      chk({t, " d_data hold"}, ddata, hold_d[k]);
      chk({t, " d_error idle"}, 32'(derr), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0, rst_a, ba.i_ack, ba.i_data, ba.d_ack, ba.d_data, ba.d_error);
    monitor_step(1, rst_b, bb.i_ack, bb.i_data, bb.d_ack, bb.d_data, bb.d_error);
  end

  task automatic drive_d(input bit b, input logic acc, input logic [31:0] addr, input logic wr,
                         input logic [3:0] be, input logic [31:0] val);
    if (b) begin
      bb.d_access = acc; bb.d_cs = 1'b1; bb.d_addr = addr; bb.d_wr_en = wr;
      bb.d_bytesel = be; bb.d_wr_val = val;
    end else begin
      ba.d_access = acc; ba.d_cs = 1'b1; ba.d_addr = addr; ba.d_wr_en = wr;
      ba.d_bytesel = be; ba.d_wr_val = val;
    end
  endtask

  task automatic drive_i(input bit b, input logic acc, input logic [31:0] addr);
    if (b) begin bb.i_access = acc; bb.i_addr = addr; end
    else   begin ba.i_access = acc; ba.i_addr = addr; end
  endtask

  // Issue one data request, hold it until d_ack, then release.
  task automatic d_req(input bit b, input logic [31:0] addr, input bit wr, input logic [3:0] be,
                       input logic [31:0] val, input logic [31:0] exp, input bit chk_data, input bit err);
    exp_t e;
    bit   got;
    int   n;
    @(negedge clk);
    e = '{inst: int'(b), data: exp, chk: chk_data, rd: !wr, err: err, due: cyc + (b ? 3 : 1)};
    qd.push_back(e);
    drive_d(b, 1'b1, addr, wr, be, val);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = b ? (bb.d_ack === 1'b1) : (ba.d_ack === 1'b1);
      n++;
    end
    if (!got) flag("d_ack timeout");
    drive_d(b, 1'b0, addr, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic fetch(input bit b, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    e = '{inst: int'(b), data: exp, chk: 1'b1, rd: 1'b1, err: 1'b0, due: cyc + 1};
    qi.push_back(e);
    drive_i(b, 1'b1, addr);
  endtask

  task automatic fetch_end(input bit b);
    @(negedge clk);
    drive_i(b, 1'b0, 32'h0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] pre;
    drive_d(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_d(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_i(1'b0, 1'b0, 32'h0);
    drive_i(1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("A rst i_ack", 32'(ba.i_ack), 32'h0);
    chk("A rst d_ack", 32'(ba.d_ack), 32'h0);
    chk("A rst d_error", 32'(ba.d_error), 32'h0);
    chk("A rst i_data", ba.i_data, 32'h0);
    chk("A rst d_data", ba.d_data, 32'h0);
    chk("B rst i_ack", 32'(bb.i_ack), 32'h0);
    chk("B rst d_ack", 32'(bb.d_ack), 32'h0);
    chk("B rst d_error", 32'(bb.d_error), 32'h0);
    chk("B rst i_data", bb.i_data, 32'h0);
    chk("B rst d_data", bb.d_data, 32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Instance A: latency 1 basics, byte lanes, empty bytesel, wrap
    d_req(1'b0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    d_req(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    d_req(1'b0, 32'h80, 1'b1, 4'hF, 32'hAAAAAAAA, 32'h0, 1'b1, 1'b0);
    d_req(1'b0, 32'h80, 1'b1, 4'b0101, 32'h11223344, 32'h0, 1'b1, 1'b0);
    d_req(1'b0, 32'h80, 1'b0, 4'hF, 32'h0, 32'hAA22AA44, 1'b1, 1'b0);
    d_req(1'b0, 32'h10, 1'b1, 4'h0, 32'h00000000, 32'h0, 1'b1, 1'b0);
    d_req(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    fetch(1'b0, 32'h10, 32'hDEADBEEF);
    fetch(1'b0, 32'h80, 32'hAA22AA44);
    fetch_end(1'b0);
    d_req(1'b0, 32'h4010, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    d_req(1'b0, 32'h10, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);

    // Deselected request must never be acked
    @(negedge clk);
    ba.d_access = 1'b1; ba.d_cs = 1'b0; ba.d_wr_en = 1'b1; ba.d_addr = 32'h10;
    repeat (3) @(negedge clk);
    drive_d(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

    // Same-edge fetch and write to one word: fetch sees the old value
    @(negedge clk);
    e = '{inst: 0, data: 32'h0, chk: 1'b1, rd: 1'b0, err: 1'b0, due: cyc + 1};
    qd.push_back(e);
    drive_d(1'b0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h0BADC0DE);
    e = '{inst: 0, data: 32'hCAFEF00D, chk: 1'b1, rd: 1'b1, err: 1'b0, due: cyc + 1};
    qi.push_back(e);
    drive_i(1'b0, 1'b1, 32'h10);
    @(negedge clk);
    drive_d(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    e = '{inst: 0, data: 32'h0BADC0DE, chk: 1'b1, rd: 1'b1, err: 1'b0, due: cyc + 1};
    qi.push_back(e);
    fetch_end(1'b0);

    // Write to a low (protectable) word
    d_req(1'b0, 32'h08, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    pre = hold_d[0];
    d_req(1'b0, 32'h08, 1'b1, 4'hF, 32'h5A5A1234, 32'h0, 1'b1, PROT_ON);
    d_req(1'b0, 32'h08, 1'b0, 4'hF, 32'h0, PROT_ON ? pre : 32'h5A5A1234, 1'b1, 1'b0);

    // Instance B: latency 3, aliasing, held request
    d_req(1'b1, 32'h40, 1'b1, 4'hF, 32'h13579BDF, 32'h0, 1'b1, 1'b0);
    fetch(1'b1, 32'h0, 32'h13579BDF);
    fetch_end(1'b1);
    d_req(1'b1, 32'h0, 1'b0, 4'hF, 32'h0, 32'h13579BDF, 1'b1, 1'b0);

    // Reset during BUSY: no ack afterwards, committed write survives
    @(negedge clk);
    drive_d(1'b1, 1'b1, 32'h14, 1'b1, 4'hF, 32'h2468ACE0);
    @(negedge clk);
    rst_b = 1'b1;
    drive_d(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    chk("B midrst d_ack", 32'(bb.d_ack), 32'h0);
    chk("B midrst d_data", bb.d_data, 32'h0);
    chk("B midrst i_data", bb.i_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (6) @(negedge clk);
    d_req(1'b1, 32'h14, 1'b0, 4'hF, 32'h0, 32'h2468ACE0, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("d scoreboard drained", 32'(qd.size()), 32'h0);
    chk("i scoreboard drained", 32'(qi.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
